rf_multiport: RTL

Parametrised, dual-write register file for the next CPU generation. It provides:
- configurable width and depth, with an optional hardwired-zero register 0;
- two combinational read ports with same-cycle write bypass, plus a debug read port with no bypass;
- a pending-write scoreboard for load-use hazard detection;
- a sequenced clear operation that zeroes the file one entry per cycle.

It sits between the decode stage (reads and scoreboard set) and the writeback stage (two write ports: ALU and load).

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_clear_seq.sv | 46 ++++
 rtl/rf_multiport.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register file, decode and writeback stages:
// default geometry and the clear-sequencer state encoding.
package rf_pkg;

  localparam int RF_DATA_W = 8;
  localparam int RF_DEPTH  = 8;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: on a clr_req pulse it walks the index from 0 to DEPTH-1,
// one entry per cycle, and then returns to idle.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] clr_idx,
  output logic              clr_we
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  rf_state_e state;

  // The index wraps to 0 on its own after the last entry since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RF_IDLE;
      clr_idx <= '0;
    end else begin
      case (state)
        RF_IDLE: begin
          if (clr_req) begin
            state   <= RF_CLEAR;
            clr_idx <= '0;
          end
        end
        RF_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) state <= RF_IDLE;
        end
        default: state <= RF_IDLE;
      endcase
    end
  end

  assign clr_busy = (state == RF_CLEAR);
  assign clr_we   = (state == RF_CLEAR);

endmodule

// File: rtl/rf_multiport.sv
// Dual-write register file with bypassed read ports, a raw debug read port,
// a load-use pending scoreboard and a sequenced clear.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic              sb_busy0,
  output logic              sb_busy1,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;
  logic [ADDR_W-1:0] clr_idx;
  logic              clr_we;
  logic              wr0_eff;
  logic              wr1_eff;
  logic              sb_eff;

  rf_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_idx  (clr_idx),
    .clr_we   (clr_we)
  );

  // Port 1 wins on read bypass to mirror its priority on the store.
  function automatic logic [DATA_W-1:0] rd_bypass(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored,
    input logic              w0_eff,
    input logic [ADDR_W-1:0] wa0,
    input logic [DATA_W-1:0] wd0,
    input logic              w1_eff,
    input logic [ADDR_W-1:0] wa1,
    input logic [DATA_W-1:0] wd1
  );
    logic [DATA_W-1:0] res;
    res = stored;
    if (w1_eff && (wa1 == ra))      res = wd1;
    else if (w0_eff && (wa0 == ra)) res = wd0;
    if (ZR && (ra == '0))           res = '0;
    return res;
  endfunction

  // Clearing blocks both write ports and scoreboard sets, which also
  // removes the read bypass while the sequence runs.
  assign wr0_eff = we0 && !clr_busy && !(ZR && (waddr0 == '0));
  assign wr1_eff = we1 && !clr_busy && !(ZR && (waddr1 == '0));
  assign sb_eff  = sb_set && !clr_busy && !(ZR && (sb_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_idx] <= '0;
    end else begin
      if (wr0_eff) mem[waddr0] <= wdata0;
      if (wr1_eff) mem[waddr1] <= wdata1;
    end
  end

  // Set is applied after the write clears so a same-cycle set wins.
  always_comb begin
    pend_nxt = pend;
    if (wr0_eff) pend_nxt[waddr0] = 1'b0;
    if (wr1_eff) pend_nxt[waddr1] = 1'b0;
    if (sb_eff)  pend_nxt[sb_addr] = 1'b1;
    if (clr_we)  pend_nxt[clr_idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;
  end

  always_comb begin
    rdata0 = rd_bypass(raddr0, mem[raddr0], wr0_eff, waddr0, wdata0,
                       wr1_eff, waddr1, wdata1);
    rdata1 = rd_bypass(raddr1, mem[raddr1], wr0_eff, waddr0, wdata0,
                       wr1_eff, waddr1, wdata1);
  end

  assign dbg_data = mem[dbg_addr];

  // A write landing this cycle resolves the hazard through the bypass.
  assign sb_busy0 = pend[raddr0] && !(wr0_eff && (waddr0 == raddr0))
                                 && !(wr1_eff && (waddr1 == raddr0));
  assign sb_busy1 = pend[raddr1] && !(wr0_eff && (waddr0 == raddr1))
                                 && !(wr1_eff && (waddr1 == raddr1));

endmodule
